mux_arb_nto1: RTL and testbench

//  Parametrised successor to the ALU's 2:1 operand mux. Selects one of N input channels of WIDTH bits

---
 rtl/mux_arb_nto1_if.sv | 37 +++
 rtl/mux_arb_nto1.sv | 117 +++++++++++
 tb/tb_mux_arb_nto1.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/mux_arb_nto1_if.sv
// Handshake bundle between N producers, the channel mux/arbiter and one consumer.
// The slave modport is the mux itself; the master modport is the producer/consumer side.
interface mux_arb_nto1_if #(
    parameter int N     = 4,
    parameter int WIDTH = 8,
    localparam int SELW = (N > 1) ? $clog2(N) : 1
);

    logic [N-1:0]       in_valid;
    logic [N*WIDTH-1:0] in_data;
    logic [N-1:0]       in_ready;
    logic               out_valid;
    logic [WIDTH-1:0]   out_data;
    logic [SELW-1:0]    out_ch;
    logic               out_ready;

    modport slave (
        input  in_valid,
        input  in_data,
        output in_ready,
        output out_valid,
        output out_data,
        output out_ch,
        input  out_ready
    );

    modport master (
        output in_valid,
        output in_data,
        input  in_ready,
        input  out_valid,
        input  out_data,
        input  out_ch,
        output out_ready
    );

endinterface

// File: rtl/mux_arb_nto1.sv
// N-to-1 channel mux with a single registered output stage and valid/ready on every port.
// The grant source is chosen at runtime: external select, round-robin, fixed priority or hold.
module mux_arb_nto1 #(
    parameter int N     = 4,
    parameter int WIDTH = 8,
    localparam int SELW = (N > 1) ? $clog2(N) : 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [1:0]      mode,
    input  logic [SELW-1:0] sel,
    mux_arb_nto1_if.slave   bus
);

    localparam int SELN = 1 << SELW;

    typedef enum logic [1:0] {
        MODE_EXT  = 2'b00,
        MODE_RR   = 2'b01,
        MODE_PRIO = 2'b10,
        MODE_HOLD = 2'b11
    } mode_t;

    logic [SELN-1:0]  valid_ext;
    logic             grant_any;
    logic [SELW-1:0]  grant_idx;
    logic [SELW-1:0]  cand;
    logic [WIDTH-1:0] grant_data;
    logic             load_en;
    logic             transfer;

    logic             out_valid_q;
    logic [WIDTH-1:0] out_data_q;
    logic [SELW-1:0]  out_ch_q;
    logic [SELW-1:0]  rr_ptr;

    // valid_ext is zero-padded to a power of two so an out-of-range select reads 0 and never grants.
    always_comb begin
        valid_ext          = '0;
        valid_ext[N-1:0]   = bus.in_valid;
        grant_any          = 1'b0;
        grant_idx          = '0;
        cand               = '0;
        case (mode_t'(mode))
            MODE_EXT: begin
                if (valid_ext[sel]) begin
                    grant_any = 1'b1;
                    grant_idx = sel;
                end
            end
            MODE_RR: begin
                for (int k = 1; k <= N; k++) begin
                    cand = SELW'((int'(rr_ptr) + k) % N);
                    if (!grant_any && valid_ext[cand]) begin
                        grant_any = 1'b1;
                        grant_idx = cand;
                    end
                end
            end
            MODE_PRIO: begin
                for (int i = N - 1; i >= 0; i--) begin
                    if (bus.in_valid[i]) begin
                        grant_any = 1'b1;
                        grant_idx = SELW'(i);
                    end
                end
            end
            default: begin
            end
        endcase
    end

    always_comb begin
        grant_data = '0;
        for (int i = 0; i < N; i++) begin
            if (grant_idx == SELW'(i)) begin
                grant_data = bus.in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    // rst_n gates the ready path so no producer sees a handshake while the block is held in reset.
    assign load_en  = !out_valid_q || bus.out_ready;
    assign transfer = rst_n && load_en && grant_any;

    always_comb begin
        bus.in_ready = '0;
        for (int i = 0; i < N; i++) begin
            bus.in_ready[i] = transfer && (grant_idx == SELW'(i));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ch_q    <= '0;
            rr_ptr      <= SELW'(N - 1);
        end else begin
            if (transfer) begin
                out_valid_q <= 1'b1;
                out_data_q  <= grant_data;
                out_ch_q    <= grant_idx;
                if (mode_t'(mode) == MODE_RR) begin
                    rr_ptr <= grant_idx;
                end
            end else if (bus.out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_ch    = out_ch_q;

endmodule

// File: tb/tb_mux_arb_nto1.sv
// Directed bench for mux_arb_nto1 (N=4, WIDTH=8): reset, select, round-robin, priority,
// backpressure and hold mode, each compared against hand-computed values.
module tb_mux_arb_nto1;

    localparam int N     = 4;
    localparam int WIDTH = 8;

    logic       clk;
    logic       rst_n;
    logic [1:0] mode;
    logic [1:0] sel;
    int         checks;
    int         failures;

    mux_arb_nto1_if #(.N(N), .WIDTH(WIDTH)) bus ();

    mux_arb_nto1 #(.N(N), .WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .mode  (mode),
        .sel   (sel),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic applyStimulus(input logic [1:0] m, input logic [1:0] s, input logic [3:0] v,
                                 input logic [31:0] d, input logic ordy);
        mode          = m;
        sel           = s;
        bus.in_valid  = v;
        bus.in_data   = d;
        bus.out_ready = ordy;
        #1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        bus.in_valid = '0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
    endtask

    localparam logic [31:0] BASE = {8'h44, 8'h33, 8'h22, 8'h11};

    initial begin
        checks        = 0;
        failures      = 0;
        rst_n         = 1'b0;
        mode          = 2'b00;
        sel           = 2'b00;
        bus.in_valid  = '0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        #12;
        rst_n = 1'b1;
        step();

        // Load a word, then hit reset mid-cycle: it must vanish at once.
        applyStimulus(2'b10, 2'd0, 4'b0001, BASE, 1'b1);
        step();
        checkOutput("pre_rst_valid", 32'(bus.out_valid), 32'd1);
        checkOutput("pre_rst_data", 32'(bus.out_data), 32'h11);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("rst_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("rst_data", 32'(bus.out_data), 32'd0);
        checkOutput("rst_ch", 32'(bus.out_ch), 32'd0);
        checkOutput("rst_ready", 32'(bus.in_ready), 32'd0);
        applyStimulus(2'b01, 2'd0, 4'b1111, BASE, 1'b1);
        checkOutput("rst_ready_allvalid", 32'(bus.in_ready), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checkOutput("rr_first_ready", 32'(bus.in_ready), 32'b0001);
        step();
        checkOutput("rr_first_ch", 32'(bus.out_ch), 32'd0);
        checkOutput("rr_first_data", 32'(bus.out_data), 32'h11);

        // Round-robin from reset: 0,1,2,3,0,1 with no bubbles.
        doReset();
        applyStimulus(2'b01, 2'd0, 4'b1111, BASE, 1'b1);
        for (int k = 0; k < 6; k++) begin
            checkOutput($sformatf("rr_ready%0d", k), 32'(bus.in_ready), 32'(1 << (k % 4)));
            step();
            checkOutput($sformatf("rr_ch%0d", k), 32'(bus.out_ch), 32'(k % 4));
            checkOutput($sformatf("rr_valid%0d", k), 32'(bus.out_valid), 32'd1);
        end

        // External select.
        applyStimulus(2'b00, 2'd2, 4'b1111, BASE, 1'b1);
        checkOutput("sel2_ready", 32'(bus.in_ready), 32'b0100);
        step();
        checkOutput("sel2_data", 32'(bus.out_data), 32'h33);
        checkOutput("sel2_ch", 32'(bus.out_ch), 32'd2);
        applyStimulus(2'b00, 2'd3, 4'b0111, BASE, 1'b1);
        checkOutput("sel3_invalid_ready", 32'(bus.in_ready), 32'd0);
        step();
        checkOutput("sel3_drain_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("sel3_keep_data", 32'(bus.out_data), 32'h33);
        checkOutput("sel3_keep_ch", 32'(bus.out_ch), 32'd2);

        // Fixed priority.
        applyStimulus(2'b10, 2'd0, 4'b1010, BASE, 1'b1);
        checkOutput("prio_ready", 32'(bus.in_ready), 32'b0010);
        step();
        checkOutput("prio_ch_a", 32'(bus.out_ch), 32'd1);
        checkOutput("prio_data_a", 32'(bus.out_data), 32'h22);
        step();
        checkOutput("prio_ch_b", 32'(bus.out_ch), 32'd1);
        checkOutput("prio_valid_b", 32'(bus.out_valid), 32'd1);
        applyStimulus(2'b10, 2'd0, 4'b1000, BASE, 1'b1);
        checkOutput("prio_drop_ready", 32'(bus.in_ready), 32'b1000);
        step();
        checkOutput("prio_drop_ch", 32'(bus.out_ch), 32'd3);
        checkOutput("prio_drop_data", 32'(bus.out_data), 32'h44);

        // Backpressure: hold 5A for three cycles, then drain and reload A5 without a bubble.
        applyStimulus(2'b00, 2'd0, 4'b1111, {8'h44, 8'h33, 8'h22, 8'h5A}, 1'b1);
        step();
        checkOutput("bp_load_data", 32'(bus.out_data), 32'h5A);
        applyStimulus(2'b00, 2'd0, 4'b1111, {8'h44, 8'h33, 8'h22, 8'hA5}, 1'b0);
        for (int k = 0; k < 3; k++) begin
            checkOutput($sformatf("bp_ready%0d", k), 32'(bus.in_ready), 32'd0);
            step();
            checkOutput($sformatf("bp_data%0d", k), 32'(bus.out_data), 32'h5A);
            checkOutput($sformatf("bp_valid%0d", k), 32'(bus.out_valid), 32'd1);
        end
        applyStimulus(2'b00, 2'd0, 4'b1111, {8'h44, 8'h33, 8'h22, 8'hA5}, 1'b1);
        checkOutput("bp_release_ready", 32'(bus.in_ready), 32'b0001);
        step();
        checkOutput("bp_reload_data", 32'(bus.out_data), 32'hA5);
        checkOutput("bp_reload_valid", 32'(bus.out_valid), 32'd1);

        // Hold mode: nothing granted, existing word drains.
        applyStimulus(2'b11, 2'd0, 4'b1111, BASE, 1'b1);
        checkOutput("hold_ready", 32'(bus.in_ready), 32'd0);
        step();
        checkOutput("hold_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("hold_keep_data", 32'(bus.out_data), 32'hA5);

        // Pointer was last moved to 1 in round-robin; other modes must not have touched it.
        applyStimulus(2'b01, 2'd0, 4'b1111, BASE, 1'b1);
        checkOutput("rr_resume_ready", 32'(bus.in_ready), 32'b0100);
        step();
        checkOutput("rr_resume_ch", 32'(bus.out_ch), 32'd2);
        checkOutput("rr_resume_data", 32'(bus.out_data), 32'h33);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
